// File: rtl/huge_page_sched_pkg.sv
// Shared definitions for the huge page scheduler: FSM encodings, default
// geometry, the close-record layout and the offset width helper.
package huge_page_pkg;

  localparam int LEN_W          = 13;
  localparam int PAGE_BYTES_DEF = 2097152;
  localparam int HDR_BYTES_DEF  = 64;
  localparam int TMO_CYCLES_DEF = 1024;

  // offset must be able to hold PAGE_BYTES itself (a completely full page)
  function automatic int off_width(input int page_bytes);
    return $clog2(page_bytes) + 1;
  endfunction

  localparam int OFF_W_DEF = off_width(PAGE_BYTES_DEF);

  localparam logic [2:0] ST_WAIT    = 3'd0;
  localparam logic [2:0] ST_READY   = 3'd1;
  localparam logic [2:0] ST_GRANT   = 3'd2;
  localparam logic [2:0] ST_CLOSE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_SETTLE  = 3'd5;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] bytes;
  } close_info_t;

endpackage

// File: rtl/huge_page_sched_if.sv
// Engine slot handshake and page-close handshake of the huge page scheduler.
// master = scheduler side, slave = DMA write engine / header writer side.
interface huge_page_sched_if
  import huge_page_pkg::*;
();

  logic              eng_req;
  logic [LEN_W-1:0]  eng_len;
  logic              eng_grant;
  logic [63:0]       eng_addr;
  logic              eng_done;
  logic              close_req;
  logic [63:0]       close_addr;
  logic [31:0]       close_bytes;
  logic              close_ack;

  modport master (
    input  eng_req, eng_len, eng_done, close_ack,
    output eng_grant, eng_addr, close_req, close_addr, close_bytes
  );

  modport slave (
    output eng_req, eng_len, eng_done, close_ack,
    input  eng_grant, eng_addr, close_req, close_addr, close_bytes
  );

endinterface

// File: rtl/huge_page_sched_flush_timer.sv
// Idle timer that closes a partially filled page. Only built when
// HUGE_PAGE_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef HUGE_PAGE_TIMEOUT_EN
module hp_flush_timer #(
  parameter int TMO_CYCLES = 1024
) (
  input  logic trn_clk,
  input  logic reset_n,
  input  logic count_en_i,
  output logic hit_o
);

  localparam int CNT_W = $clog2(TMO_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // count idle cycles; any break in the idle condition restarts from zero
  always_comb begin
    cnt_d = count_en_i ? cnt_q + CNT_W'(1) : '0;
  end

  // counter register
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign hit_o = count_en_i && (cnt_q == CNT_W'(TMO_CYCLES - 1));

endmodule
`endif

// File: rtl/huge_page_sched.sv
// Ping-pong scheduler for the two host huge pages: hands out write slots,
// tracks the fill offset, closes a page (header write, then return to host).
// Optional idle-close timer: define HUGE_PAGE_TIMEOUT_EN.
//
//   state      | meaning
//   WAIT       | current page not yet owned by hardware
//   READY      | page owned, waiting for an engine request
//   GRANT      | slot granted, waiting for eng_done
//   CLOSE      | header write requested, waiting for close_ack
//   RELEASE    | one-cycle to_host pulse for the current page
//   SETTLE     | idle cycle so the decoder's to_hw deassert is seen
module huge_page_sched
  import huge_page_pkg::*;
#(
  parameter int PAGE_BYTES = PAGE_BYTES_DEF,
  parameter int HDR_BYTES  = HDR_BYTES_DEF
`ifdef HUGE_PAGE_TIMEOUT_EN
  , parameter int TMO_CYCLES = TMO_CYCLES_DEF
`endif
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic        huge_page_to_hw_1,
  input  logic        huge_page_to_hw_2,
  output logic        huge_page_to_host_1,
  output logic        huge_page_to_host_2,
  output logic        cur_page,
  huge_page_sched_if.master bus
);

  localparam int OFF_W = off_width(PAGE_BYTES);

  logic [2:0]       state_q,    state_d;
  logic             cur_page_q, cur_page_d;
  logic [OFF_W-1:0] offset_q,   offset_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic             grant_q,    grant_d;
  logic [63:0]      eaddr_q,    eaddr_d;
  logic             creq_q,     creq_d;
  close_info_t      cinfo_q,    cinfo_d;
  logic             host1_q,    host1_d;
  logic             host2_q,    host2_d;

  logic [63:0]      base;
  logic             own;
  logic [OFF_W:0]   fit_sum;
  logic             fits;
  logic [OFF_W-1:0] grant_off;
  logic             tmo_hit;

  function automatic logic [31:0] payload(input logic [OFF_W-1:0] off);
    return 32'(off - OFF_W'(HDR_BYTES));
  endfunction

  assign base      = cur_page_q ? huge_page_addr_2  : huge_page_addr_1;
  assign own       = cur_page_q ? huge_page_to_hw_2 : huge_page_to_hw_1;
  assign fit_sum   = {1'b0, offset_q} + {{(OFF_W + 1 - LEN_W){1'b0}}, bus.eng_len};
  assign fits      = fit_sum <= (OFF_W + 1)'(PAGE_BYTES);
  assign grant_off = offset_q + OFF_W'(len_q);

`ifdef HUGE_PAGE_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state_q == ST_READY) && (offset_q > OFF_W'(HDR_BYTES)) && !bus.eng_req;

  hp_flush_timer #(.TMO_CYCLES(TMO_CYCLES)) u_flush_timer (
    .trn_clk    (trn_clk),
    .reset_n    (reset_n),
    .count_en_i (tmo_en),
    .hit_o      (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // page sequencing: slot grants, offset tracking, close and page switch
  always_comb begin
    state_d    = state_q;
    cur_page_d = cur_page_q;
    offset_d   = offset_q;
    len_d      = len_q;
    grant_d    = grant_q;
    eaddr_d    = eaddr_q;
    creq_d     = creq_q;
    cinfo_d    = cinfo_q;
    host1_d    = 1'b0;
    host2_d    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (own) state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.eng_req) begin
          if (fits) begin
            state_d = ST_GRANT;
            grant_d = 1'b1;
            eaddr_d = base + 64'(offset_q);
            len_d   = bus.eng_len;
          end else begin
            // request stays pending and is served from the next page
            state_d = ST_CLOSE;
            creq_d  = 1'b1;
            cinfo_d = '{addr: base, bytes: payload(offset_q)};
          end
        end else if (tmo_hit) begin
          state_d = ST_CLOSE;
          creq_d  = 1'b1;
          cinfo_d = '{addr: base, bytes: payload(offset_q)};
        end
      end
      ST_GRANT: begin
        if (bus.eng_done) begin
          grant_d  = 1'b0;
          offset_d = grant_off;
          if (grant_off == OFF_W'(PAGE_BYTES)) begin
            state_d = ST_CLOSE;
            creq_d  = 1'b1;
            cinfo_d = '{addr: base, bytes: payload(grant_off)};
          end else begin
            state_d = ST_READY;
          end
        end
      end
      ST_CLOSE: begin
        if (bus.close_ack) begin
          state_d = ST_RELEASE;
          creq_d  = 1'b0;
          cinfo_d = '0;
          host1_d = !cur_page_q;
          host2_d = cur_page_q;
        end
      end
      ST_RELEASE: begin
        state_d    = ST_SETTLE;
        cur_page_d = !cur_page_q;
        offset_d   = OFF_W'(HDR_BYTES);
      end
      ST_SETTLE: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // state registers; reset aborts any grant or close in flight
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT;
      cur_page_q <= 1'b0;
      offset_q   <= OFF_W'(HDR_BYTES);
      len_q      <= '0;
      grant_q    <= 1'b0;
      eaddr_q    <= '0;
      creq_q     <= 1'b0;
      cinfo_q    <= '0;
      host1_q    <= 1'b0;
      host2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_page_q <= cur_page_d;
      offset_q   <= offset_d;
      len_q      <= len_d;
      grant_q    <= grant_d;
      eaddr_q    <= eaddr_d;
      creq_q     <= creq_d;
      cinfo_q    <= cinfo_d;
      host1_q    <= host1_d;
      host2_q    <= host2_d;
    end
  end

  assign bus.eng_grant       = grant_q;
  assign bus.eng_addr        = eaddr_q;
  assign bus.close_req       = creq_q;
  assign bus.close_addr      = cinfo_q.addr;
  assign bus.close_bytes     = cinfo_q.bytes;
  assign huge_page_to_host_1 = host1_q;
  assign huge_page_to_host_2 = host2_q;
  assign cur_page            = cur_page_q;

endmodule

// File: tb/tb_huge_page_sched.sv
// Directed bench for huge_page_sched with a small ping-pong page model that
// predicts slot addresses and close records into scoreboard queues.
module tb_huge_page_sched;
  import huge_page_pkg::*;

  localparam int PAGE = 2097152;
  localparam int HDR  = 64;
  localparam int TMO  = 16;
  localparam logic [63:0] A1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] A2 = 64'h0000_0002_0040_0000;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] bytes;
    logic        page;
  } cls_t;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] addr1, addr2;
  logic        hw1, hw2;
  logic        host1, host2, cur_page;

  huge_page_sched_if bus();

  always #5 trn_clk = ~trn_clk;

`ifdef HUGE_PAGE_TIMEOUT_EN
  huge_page_sched #(.TMO_CYCLES(TMO)) dut (
`else
  huge_page_sched dut (
`endif
    .trn_clk             (trn_clk),
    .reset_n             (reset_n),
    .huge_page_addr_1    (addr1),
    .huge_page_addr_2    (addr2),
    .huge_page_to_hw_1   (hw1),
    .huge_page_to_hw_2   (hw2),
    .huge_page_to_host_1 (host1),
    .huge_page_to_host_2 (host2),
    .cur_page            (cur_page),
    .bus                 (bus)
  );

  logic [63:0] exp_q[$];
  cls_t        cls_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_page = 0;
  int          m_off  = HDR;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] page_base(input int p);
    return (p != 0) ? A2 : A1;
  endfunction

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic model_close();
    cls_q.push_back('{page_base(m_page), 32'(m_off - HDR), 1'(m_page)});
    m_page ^= 1;
    m_off = HDR;
  endtask

  task automatic model_reset();
    m_page = 0;
    m_off  = HDR;
    exp_q.delete();
    cls_q.delete();
  endtask

  task automatic req_push(input int len);
    if (m_off + len > PAGE) model_close();
    exp_q.push_back(page_base(m_page) + 64'(m_off));
    m_off += len;
    if (m_off == PAGE) model_close();
    bus.eng_req = 1'b1;
    bus.eng_len = LEN_W'(len);
  endtask

  task automatic wait_grant(input string tag, input int max);
    int n = 0;
    logic [63:0] e;
    do begin
      step();
      n++;
    end while (!bus.eng_grant && n < max);
    check({tag, "_grant"}, 64'(bus.eng_grant), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_addr"}, bus.eng_addr, e);
    bus.eng_req = 1'b0;
  endtask

  task automatic done_pulse();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    check("grant_drop", 64'(bus.eng_grant), 64'd0);
  endtask

  task automatic wait_close(input string tag, input int max);
    int n = 0;
    cls_t c;
    while (!bus.close_req && n < max) begin
      step();
      n++;
    end
    check({tag, "_req"}, 64'(bus.close_req), 64'd1);
    if (cls_q.size() > 0) c = cls_q.pop_front();
    else c = '{64'hx, 32'hx, 1'bx};
    check({tag, "_addr"}, bus.close_addr, c.addr);
    check({tag, "_bytes"}, 64'(bus.close_bytes), 64'(c.bytes));
    check({tag, "_nogrant"}, 64'(bus.eng_grant), 64'd0);
    bus.close_ack = 1'b1;
    step();
    bus.close_ack = 1'b0;
    check({tag, "_req_drop"}, 64'(bus.close_req), 64'd0);
    check({tag, "_host_pulse"}, 64'({host2, host1}), c.page ? 64'd2 : 64'd1);
    step();
    check({tag, "_host_end"}, 64'({host2, host1}), 64'd0);
    check({tag, "_cur_page"}, 64'(cur_page), 64'(!c.page));
    if (c.page) hw2 = 1'b0;
    else        hw1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    addr1 = A1;
    addr2 = A2;
    hw1 = 1'b0;
    hw2 = 1'b0;
    bus.eng_req = 1'b0;
    bus.eng_len = '0;
    bus.eng_done = 1'b0;
    bus.close_ack = 1'b0;

    repeat (3) step();
    check("rst_grant", 64'(bus.eng_grant), 64'd0);
    check("rst_eaddr", bus.eng_addr, 64'd0);
    check("rst_creq", 64'(bus.close_req), 64'd0);
    check("rst_caddr", bus.close_addr, 64'd0);
    check("rst_cbytes", 64'(bus.close_bytes), 64'd0);
    check("rst_host", 64'({host2, host1}), 64'd0);
    check("rst_cur_page", 64'(cur_page), 64'd0);
    reset_n = 1'b1;
    step();

    // page 1: first slots, then fill exactly to the end
    hw1 = 1'b1;
    step();
    req_push(256);
    wait_grant("p1_256", 1);
    check("p1_256_const", bus.eng_addr, 64'h1_0000_0040);
    done_pulse();
    req_push(8);
    wait_grant("p1_8", 1);
    check("p1_8_const", bus.eng_addr, 64'h1_0000_0140);
    done_pulse();
    for (int i = 0; i < 511; i++) begin
      req_push(4096);
      wait_grant("fill1", 1);
      done_pulse();
    end
    req_push(3768);
    wait_grant("fill1_last", 1);
    done_pulse();
    wait_close("close_full", 4);

    // page 2 not yet owned: request must wait
    req_push(64);
    seen = 0;
    repeat (20) begin
      step();
      seen |= int'(bus.eng_grant);
    end
    check("wait_no_grant", 64'(seen), 64'd0);
    hw2 = 1'b1;
    step();
    check("ready_no_grant_yet", 64'(bus.eng_grant), 64'd0);
    wait_grant("p2_first", 1);

    // reset in the middle of a grant
    reset_n = 1'b0;
    #1;
    check("arst_grant", 64'(bus.eng_grant), 64'd0);
    check("arst_eaddr", bus.eng_addr, 64'd0);
    check("arst_creq", 64'(bus.close_req), 64'd0);
    check("arst_host", 64'({host2, host1}), 64'd0);
    check("arst_cur_page", 64'(cur_page), 64'd0);
    model_reset();
    hw2 = 1'b0;
    hw1 = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    step();

    // page 1 to 64 bytes short of full, then a request that does not fit
    for (int i = 0; i < 511; i++) begin
      req_push(4096);
      wait_grant("fill2", 1);
      done_pulse();
    end
    req_push(3968);
    wait_grant("fill2_last", 1);
    done_pulse();
    req_push(128);
    wait_close("close_nofit", 4);
    repeat (5) step();
    check("held_req_no_grant", 64'(bus.eng_grant), 64'd0);
    hw2 = 1'b1;
    wait_grant("nofit_switch", 4);
    done_pulse();

    // idle close of a partially filled page
    hw1 = 1'b1;
    hw2 = 1'b0;
    reset_n = 1'b0;
    step();
    model_reset();
    reset_n = 1'b1;
    step();
    step();
    req_push(64);
    wait_grant("tmo_slot", 1);
    done_pulse();
    n = 0;
    while (!bus.close_req && n < 200) begin
      step();
      n++;
    end
`ifdef HUGE_PAGE_TIMEOUT_EN
    check("tmo_cycles", 64'(n), 64'(TMO));
    check("tmo_creq", 64'(bus.close_req), 64'd1);
    check("tmo_bytes", 64'(bus.close_bytes), 64'd64);
    check("tmo_addr", bus.close_addr, A1);
`else
    check("no_tmo_close", 64'(bus.close_req), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huge_page_sched.md
Name: huge_page_sched

Overview:
- Sequences DMA use of the two host huge pages that the BAR2 register decoder announces via huge_page_to_hw_1/2 and huge_page_addr_1/2.
- Hands write slots to one DMA write engine in strict ping-pong order (page 1, page 2, page 1, ...).
- Tracks the fill offset of the current page and closes the page when it is full or has gone idle.
- Closing means: request a header/status write, then return the page to the host with a huge_page_to_host pulse.

Parameters:
- PAGE_BYTES, 2097152, huge page size in bytes (power of two).
- HDR_BYTES, 64, bytes reserved at page start for the close header; first payload offset.
- LEN_W, 13, width of eng_len; maximum request is 4096 bytes.
- TMO_CYCLES, 1024, idle cycles before a partially filled page is closed (optional feature only).

Ports:
- trn_clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- huge_page_addr_1  in  64  host physical address of page 1
- huge_page_addr_2  in  64  host physical address of page 2
- huge_page_to_hw_1  in  1  level: page 1 owned by hardware
- huge_page_to_hw_2  in  1  level: page 2 owned by hardware
- huge_page_to_host_1  out  1  one-cycle pulse: page 1 returned to host
- huge_page_to_host_2  out  1  one-cycle pulse: page 2 returned to host
- eng_req  in  1  engine requests a slot; held until eng_grant
- eng_len  in  LEN_W  requested bytes; nonzero, multiple of 8, at most 4096
- eng_grant  out  1  slot granted; held until eng_done
- eng_addr  out  64  slot start address, valid while eng_grant
- eng_done  in  1  one-cycle pulse: engine has issued all TLPs for the slot
- close_req  out  1  request header write; held until close_ack
- close_addr  out  64  header address (page base)
- close_bytes  out  32  payload bytes written to the page (excludes header)
- close_ack  in  1  one-cycle pulse: header write issued
- cur_page  out  1  0 = page 1 active, 1 = page 2 active

Behaviour:
- Reset values: all outputs 0; fsm=WAIT; cur_page=0; offset=HDR_BYTES; timer=0. Async reset mid-operation aborts any grant or close immediately.
- Shared internals: offset is byte-granular, LEN_W+? bits wide enough for PAGE_BYTES. base = cur_page ? huge_page_addr_2 : huge_page_addr_1. own = the selected huge_page_to_hw_x.
- WAIT: stay until own=1, then go to READY. The addresses are stable once own=1.
- READY, when eng_req=1:
  - If offset+eng_len <= PAGE_BYTES (equality fits): next cycle eng_grant=1, eng_addr=base+offset, go to GRANT. Latency from req to grant is 1 cycle.
  - Else go to CLOSE. The request stays pending and is served on the next page.
- GRANT: eng_req is ignored. On eng_done: offset += len latched at grant, drop eng_grant. If the new offset == PAGE_BYTES go to CLOSE, else go to READY. eng_done outside GRANT is ignored.
- CLOSE: close_req=1, close_addr=base, close_bytes=offset-HDR_BYTES, all held stable. On close_ack: drop close_req, go to RELEASE.
- RELEASE: one cycle with huge_page_to_host_x=1 for the current page. Then toggle cur_page, reset offset to HDR_BYTES, and go to SETTLE.
- SETTLE: one idle cycle so the decoder's huge_page_to_hw_x deassert is observed; then go to WAIT.
- The other page's huge_page_to_hw is ignored until the switch. A page can never be closed empty (offset==HDR_BYTES): a CLOSE from READY only happens when a request does not fit a non-empty page.
- Simultaneous events:
  - eng_done and eng_req in the same cycle: the req is evaluated in READY on the following cycle.
  - close_ack together with a new eng_req: the req is held until the next page reaches READY.

Optional Feature:
- HUGE_PAGE_TIMEOUT_EN defined: in READY with offset>HDR_BYTES and eng_req=0, the timer increments each cycle. The timer clears on eng_req or on leaving READY. When timer reaches TMO_CYCLES-1, go to CLOSE.
- Not defined: no timer logic; pages close only when full or when a request does not fit.

Decomposition:
- Package huge_page_pkg: fsm state encodings (WAIT, READY, GRANT, CLOSE, RELEASE, SETTLE); default PAGE_BYTES and HDR_BYTES; offset width localparam.
- Sub-module hp_flush_timer: the timeout counter, instantiated only under HUGE_PAGE_TIMEOUT_EN.

Test Plan:
- Reset, raise to_hw_1 with addr_1=0x1_0000_0000, req len=256 -> grant after 1 cycle, eng_addr=0x1_0000_0040; after done, next req len=8 -> eng_addr=0x1_0000_0140.
- Fill page 1 exactly to PAGE_BYTES with 4096-byte slots -> after the final done: close_req with close_bytes=2097088; after ack: to_host_1 pulse of 1 cycle, cur_page=1.
- Offset at 2097152-64 with req len=128 -> CLOSE without grant; after ack and to_hw_2=1, the req is granted at addr_2+64.
- Page 2 not yet owned at switch -> held in WAIT, no grant; raise to_hw_2 -> READY and grant on the next cycle.
- With HUGE_PAGE_TIMEOUT_EN and TMO_CYCLES=16: one 64-byte write then idle -> close_req after 16 cycles, close_bytes=64. Without the macro: no close.
- Assert reset_n=0 during GRANT -> eng_grant and all outputs 0 immediately, cur_page=0, fsm=WAIT.
